// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, default widths and
// the latched transaction payload.
package ram_arb_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic                  owner;
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } txn_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; a tie goes to the requester that
// was not granted last.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_id_c,
  output logic gnt_vld_c
);

  always_comb begin
    gnt_vld_c = req0 | req1;
    gnt_id_c  = 1'b0;
    if (req0 && req1) begin
      gnt_id_c = ~last;
    end else if (req1) begin
      gnt_id_c = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and strobe sequencer in front of a single-ported word
// RAM; one transaction at a time, every RAM-side output registered.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_r,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_o
);

  state_e            state_q, state_d;
  txn_t              txn_q, txn_d;
  logic              last_q, last_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              mem_r_q, mem_r_d, mem_w_q, mem_w_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_d_q, mem_d_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt_id_c, gnt_vld_c;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_rr (
    .req0      (req0),
    .req1      (req1),
    .last      (last_q),
    .gnt_id_c  (gnt_id_c),
    .gnt_vld_c (gnt_vld_c)
  );

  assign sel_we    = gnt_id_c ? we1    : we0;
  assign sel_addr  = gnt_id_c ? addr1  : addr0;
  assign sel_wdata = gnt_id_c ? wdata1 : wdata0;

  // Next state; strobes and ack are computed one state early so they land registered.
  always_comb begin
    state_d    = state_q;
    txn_d      = txn_q;
    last_d     = last_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    mem_r_d    = 1'b0;
    mem_w_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    rdata_d    = rdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_vld_c) begin
          txn_d = '{owner: gnt_id_c, we: sel_we,
                    addr: ADDR_W_DEF'(sel_addr), wdata: DATA_W_DEF'(sel_wdata)};
          last_d     = gnt_id_c;
          mem_addr_d = sel_addr;
          mem_w_d    = sel_we;
          mem_r_d    = ~sel_we;
          if (sel_we) begin
            mem_d_d = sel_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_addr_d = ADDR_W'(txn_q.addr);
        if (txn_q.we) begin
          mem_d_d = DATA_W'(txn_q.wdata);
          ack0_d  = ~txn_q.owner;
          ack1_d  = txn_q.owner;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        rdata_d = mem_o;
        ack0_d  = ~txn_q.owner;
        ack1_d  = txn_q.owner;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      txn_q      <= '0;
      last_q     <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_r_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      txn_q      <= txn_d;
      last_q     <= last_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
      mem_r_q    <= mem_r_d;
      mem_w_q    <= mem_w_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign mem_r    = mem_r_q;
  assign mem_w    = mem_w_q;
  assign mem_addr = mem_addr_q;
  assign mem_d    = mem_d_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomised bench for ram_arbiter with a behavioural RAM and a
// reference memory for read data.
module tb_ram_arbiter;

  logic        clk, rst;
  logic        req0, req1, we0, we1;
  logic [5:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, busy, mem_r, mem_w;
  logic [15:0] rdata, mem_d, mem_o;
  logic [5:0]  mem_addr;

  logic [15:0] ram [64];
  logic [15:0] ref_mem [64];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_ack, n_strobe, n_tie;
  bit          pend [2];

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_o(mem_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-ported RAM: registered read on mem_r.
  always @(posedge clk) begin
    if (mem_w) ram[mem_addr] <= mem_d;
    if (mem_r) mem_o <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("strobe_excl", 32'(mem_r & mem_w), 32'd0);
    check("ack_excl", 32'(ack0 & ack1), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit we, input logic [5:0] a, input logic [15:0] d);
    if (id) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  // Uncontended transaction from IDLE, checking every cycle of the sequence.
  task automatic run_txn(input bit id, input bit we, input logic [5:0] a,
                         input logic [15:0] d, input logic [15:0] exp);
    set_req(id, we, a, d);
    step();
    check("iss_w", 32'(mem_w), 32'(we));
    check("iss_r", 32'(mem_r), 32'(!we));
    check("iss_addr", 32'(mem_addr), 32'(a));
    check("iss_ack", 32'({ack0, ack1}), 32'd0);
    if (we) check("iss_d", 32'(mem_d), 32'(d));
    if (!we) begin
      step();
      check("wait_strb", 32'({mem_r, mem_w}), 32'd0);
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_addr", 32'(mem_addr), 32'(a));
      check("wait_ack", 32'({ack0, ack1}), 32'd0);
    end
    step();
    check("done_ack0", 32'(ack0), 32'(!id));
    check("done_ack1", 32'(ack1), 32'(id));
    if (!we) check("done_rdata", 32'(rdata), 32'(exp));
    if (id) req1 = 1'b0; else req0 = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ack", 32'({ack0, ack1}), 32'd0);
    if (!we) check("rdata_hold", 32'(rdata), 32'(exp));
  endtask

  task automatic new_req(input int i);
    bit          w;
    logic [5:0]  a;
    logic [15:0] d;
    w = 1'($urandom_range(0, 1));
    a = 6'(40 + $urandom_range(0, 3));
    d = 16'($urandom_range(0, 65535));
    set_req(1'(i), w, a, d);
    pend[i] = 1'b1;
  endtask

  task automatic on_ack(input int i);
    bit          w;
    logic [5:0]  a;
    logic [15:0] d;
    w = (i == 1) ? we1 : we0;
    a = (i == 1) ? addr1 : addr0;
    d = (i == 1) ? wdata1 : wdata0;
    check("rnd_ack_owner", 32'(pend[i]), 32'd1);
    if (w) ref_mem[a] = d;
    else check("rnd_rdata", 32'(rdata), 32'(ref_mem[a]));
    pend[i] = 1'b0;
    if (i == 1) req1 = 1'b0; else req0 = 1'b0;
    n_ack++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    mem_o = 16'h0;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset held with a pending request: everything stays zero.
    set_req(1'b0, 1'b1, 6'd5, 16'h1234);
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_ctl", 32'({ack0, ack1, busy, mem_r, mem_w}), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_d", 32'(mem_d), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
    end
    rst = 1'b0;
    run_txn(1'b0, 1'b1, 6'd5, 16'h1234, 16'h0);

    // Single write then read back.
    run_txn(1'b0, 1'b1, 6'd15, 16'h0040, 16'h0);
    run_txn(1'b0, 1'b0, 6'd15, 16'h0, 16'h0040);

    // Late arrival: req1 rises during requester 0's WAIT.
    set_req(1'b0, 1'b0, 6'd15, 16'h0);
    step();
    check("late_iss_r", 32'(mem_r), 32'd1);
    step();
    set_req(1'b1, 1'b1, 6'd20, 16'hBEEF);
    step();
    check("late_ack0", 32'(ack0), 32'd1);
    check("late_rdata", 32'(rdata), 32'h0040);
    check("late_nostrb", 32'({mem_r, mem_w}), 32'd0);
    req0 = 1'b0;
    step();
    check("late_idle", 32'({busy, mem_w, ack0, ack1}), 32'd0);
    step();
    check("late_iss_w", 32'(mem_w), 32'd1);
    check("late_addr", 32'(mem_addr), 32'd20);
    check("late_d", 32'(mem_d), 32'hBEEF);
    step();
    check("late_ack1", 32'(ack1), 32'd1);
    req1 = 1'b0;
    step();

    // Reset during WAIT aborts the read without an ack.
    set_req(1'b1, 1'b0, 6'd20, 16'h0);
    step();
    step();
    check("abort_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    req1 = 1'b0;
    step();
    check("abort_ctl", 32'({ack0, ack1, busy, mem_r, mem_w}), 32'd0);
    rst = 1'b0;
    step();
    check("abort_noack", 32'({ack0, ack1, busy}), 32'd0);
    run_txn(1'b1, 1'b0, 6'd20, 16'h0, 16'hBEEF);

    // Tie with both held: grants alternate starting with requester 0.
    set_req(1'b0, 1'b1, 6'd11, 16'h004E);
    set_req(1'b1, 1'b0, 6'd11, 16'h0);
    n_tie = 0;
    for (int c = 0; c < 40 && n_tie < 4; c++) begin
      step();
      if (ack0 || ack1) begin
        check("tie_order", 32'(ack1), 32'(n_tie % 2));
        if (ack1) check("tie_rdata", 32'(rdata), 32'h004E);
        n_tie++;
      end
    end
    check("tie_cnt", 32'(n_tie), 32'd4);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check("tie_idle", 32'(busy), 32'd0);

    // Random traffic against the reference memory.
    n_ack = 0;
    n_strobe = 0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (mem_r || mem_w) n_strobe++;
      for (int i = 0; i < 2; i++) begin
        if ((i == 0) ? ack0 : ack1) on_ack(i);
        else if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      end
      step();
    end
    for (int c = 0; c < 40 && (pend[0] || pend[1]); c++) begin
      if (mem_r || mem_w) n_strobe++;
      if (ack0) on_ack(0);
      if (ack1) on_ack(1);
      step();
    end
    check("rnd_pending", 32'({pend[0], pend[1]}), 32'd0);
    check("rnd_grants", 32'(n_strobe), 32'(n_ack));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
